cpu_program_sequencer: RTL and testbench
========================================

# cpu_program_sequencer

Parametrised, writable program store and sequencer that feeds the cpu instruction/data pairs and drives its start/done handshake. It replaces the fixed single-program ROM stepped by `done`. It adds several selectable program regions, run-once, loop and single-step modes, HALT detection, a done-timeout fault, and abort. It sits between the board top level (switches/keys) and the cpu.

## Interface
Parameters:
- INSTR_W, 9, instruction width
- DATA_W, 16, data_var width
- DEPTH, 64, total entries; power of two
- NUM_PROGS, 4, program regions; power of two, divides DEPTH; REGION = DEPTH/NUM_PROGS
- HALT_OP, all ones (INSTR_W bits), instruction value that ends a program
- TIMEOUT, 255, max WAIT cycles before fault; 0 disables the timeout

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- go  in  1  start from IDLE/HALTED, or advance from PAUSE; single-cycle pulse
- abort  in  1  synchronous; returns to IDLE from any state
- prog_sel  in  clog2(NUM_PROGS)  region to run; latched on start
- loop_mode  in  1  wrap to region base instead of halting
- step_mode  in  1  pause after each instruction
- wr_en  in  1  program-store write strobe
- wr_addr  in  clog2(DEPTH)  write address
- wr_instr  in  INSTR_W  instruction to write
- wr_data  in  DATA_W  data_var to write
- cpu_done  in  1  cpu completion flag
- cpu_start  out  1  request to cpu
- instruction  out  INSTR_W  registered instruction to cpu
- data_var  out  DATA_W  registered data to cpu
- pc  out  clog2(DEPTH)  absolute address of current entry
- busy  out  1  high in ISSUE/WAIT/RELEASE/PAUSE
- halted  out  1  program ended normally
- fault  out  1  done timeout occurred

## Operation
- Reset values: cpu_start=0, instruction=0, data_var=0, pc=0, busy=0, halted=0, fault=0, state IDLE. Store contents are not reset.
- Store: DEPTH x (INSTR_W+DATA_W) synchronous write, any state. A write lands one cycle after wr_en. An entry already latched into instruction/data_var is unaffected.
- States: IDLE, FETCH, ISSUE, WAIT, RELEASE, PAUSE, HALTED, FAULT.
- IDLE/HALTED + go: latch prog_sel; pc = prog_sel*REGION; clear halted; -> FETCH.
- FETCH: read mem[pc].
  - If the instruction == HALT_OP -> HALTED, without issuing.
  - Otherwise register instruction/data_var -> ISSUE.
- ISSUE: cpu_start=1 -> WAIT.
- WAIT: cpu_start held 1; timeout counter increments each cycle.
  - cpu_done=1 -> RELEASE with cpu_start=0.
  - If the counter reaches TIMEOUT with TIMEOUT>0 and no done -> FAULT.
- RELEASE: wait for cpu_done=0. Then:
  - If pc is the last entry of the region (pc mod REGION = REGION-1): loop_mode=1 -> pc = base, else -> HALTED.
  - Otherwise pc+1.
  - Then step_mode=1 -> PAUSE, else -> FETCH. A HALTED exit ignores step_mode.
- PAUSE: go -> FETCH.
- FAULT: fault=1, cpu_start=0. Left only by abort or rst.
- abort clears fault and halted, sets cpu_start=0 and -> IDLE. pc/instruction/data_var hold their values. abort beats go in the same cycle.
- go is ignored in FETCH/ISSUE/WAIT/RELEASE/FAULT. prog_sel changes mid-run are ignored. loop_mode is sampled at region end; step_mode is sampled at RELEASE exit.
- pc never leaves the latched region; wrap is base-relative.

## Timing
- go in cycle N -> FETCH in N+1 -> instruction valid in N+2 -> cpu_start=1 in N+2 (ISSUE).
- cpu_done sampled 1 in cycle M -> cpu_start=0 in M+1.
- Minimum per instruction: 4 cycles (FETCH, ISSUE, WAIT≥1, RELEASE≥1).
- Fault: cpu_start high for TIMEOUT+1 cycles (ISSUE + TIMEOUT WAIT) with no done -> fault=1 the next cycle.
- halted and fault are registered and stay set until the next start, abort, or rst.
- rst mid-operation: all outputs drop to reset values immediately (asynchronous); store is preserved.

## Test plan
- Load region 1 (base 16) with three entries then HALT_OP at 19. Pulse go with prog_sel=1; cpu model raises done 3 cycles after start. Required: instruction/data_var sequence matches entries, pc 16,17,18; halted=1, busy=0, cpu_start never high for entry 19.
- Region 0 filled without HALT_OP, loop_mode=1. Required: pc wraps 15->0 and run continues. Clear loop_mode at 15: halted=1 after entry 15.
- step_mode=1. Required: PAUSE after each RELEASE with busy=1, cpu_start=0; each go advances exactly one entry.
- TIMEOUT=8, cpu never asserts done. Required: cpu_start high for 9 cycles, then fault=1 and cpu_start=0. go ignored; abort -> IDLE with fault=0.
- Assert rst during WAIT. Required: all outputs zero asynchronously. go after release runs from region base with the old program intact.
- Write the currently-issued address during WAIT. Required: instruction output unchanged. A looped re-fetch of that address returns the new value.

Source files
------------

// File: rtl/cpu_program_sequencer.sv
// Writable multi-region program store and sequencer that feeds the cpu
// instruction/data pairs and runs its start/done handshake.
module cpu_program_sequencer #(
   parameter int                   INSTR_W   = 9,
   parameter int                   DATA_W    = 16,
   parameter int                   DEPTH     = 64,
   parameter int                   NUM_PROGS = 4,
   parameter logic [INSTR_W-1:0]   HALT_OP   = '1,
   parameter int                   TIMEOUT   = 255
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         go,
   input  logic                         abort,
   input  logic [$clog2(NUM_PROGS)-1:0] prog_sel,
   input  logic                         loop_mode,
   input  logic                         step_mode,
   input  logic                         wr_en,
   input  logic [$clog2(DEPTH)-1:0]     wr_addr,
   input  logic [INSTR_W-1:0]           wr_instr,
   input  logic [DATA_W-1:0]            wr_data,
   input  logic                         cpu_done,
   output logic                         cpu_start,
   output logic [INSTR_W-1:0]           instruction,
   output logic [DATA_W-1:0]            data_var,
   output logic [$clog2(DEPTH)-1:0]     pc,
   output logic                         busy,
   output logic                         halted,
   output logic                         fault
);

   localparam int AW     = $clog2(DEPTH);
   localparam int PW     = $clog2(NUM_PROGS);
   localparam int REGION = DEPTH / NUM_PROGS;
   localparam int RW     = $clog2(REGION);
   localparam int TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [AW-1:0] OFS_MASK = AW'(REGION - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_FETCH   = 3'd1;
   localparam logic [2:0] S_ISSUE   = 3'd2;
   localparam logic [2:0] S_WAIT    = 3'd3;
   localparam logic [2:0] S_RELEASE = 3'd4;
   localparam logic [2:0] S_PAUSE   = 3'd5;
   localparam logic [2:0] S_HALTED  = 3'd6;
   localparam logic [2:0] S_FAULT   = 3'd7;

   logic [INSTR_W+DATA_W-1:0] mem [DEPTH];

   logic [2:0]         state_q,  state_d;
   logic [AW-1:0]      pc_q,     pc_d;
   logic [PW-1:0]      prog_q,   prog_d;
   logic [INSTR_W-1:0] instr_q,  instr_d;
   logic [DATA_W-1:0]  data_q,   data_d;
   logic               start_q,  start_d;
   logic               halted_q, halted_d;
   logic               fault_q,  fault_d;
   logic [TW-1:0]      tmo_q,    tmo_d;

   logic [INSTR_W-1:0] rd_instr;
   logic [DATA_W-1:0]  rd_data;
   logic [AW-1:0]      base;
   logic               region_end;

   function automatic logic [AW-1:0] base_of(input logic [PW-1:0] p);
      return AW'(p) << RW;
   endfunction

   // Store has no reset so programs survive rst.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= {wr_instr, wr_data};
      end
   end

   assign {rd_instr, rd_data} = mem[pc_q];
   assign base                = base_of(prog_q);
   assign region_end          = (pc_q & OFS_MASK) == OFS_MASK;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      prog_d   = prog_q;
      instr_d  = instr_q;
      data_d   = data_q;
      start_d  = start_q;
      halted_d = halted_q;
      fault_d  = fault_q;
      tmo_d    = tmo_q;

      if (abort) begin
         state_d  = S_IDLE;
         start_d  = 1'b0;
         halted_d = 1'b0;
         fault_d  = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE, S_HALTED: begin
               if (go) begin
                  prog_d   = prog_sel;
                  pc_d     = base_of(prog_sel);
                  halted_d = 1'b0;
                  state_d  = S_FETCH;
               end
            end
            S_FETCH: begin
               if (rd_instr == HALT_OP) begin
                  halted_d = 1'b1;
                  state_d  = S_HALTED;
               end else begin
                  instr_d = rd_instr;
                  data_d  = rd_data;
                  start_d = 1'b1;
                  tmo_d   = '0;
                  state_d = S_ISSUE;
               end
            end
            S_ISSUE: begin
               state_d = S_WAIT;
            end
            S_WAIT: begin
               if (cpu_done) begin
                  start_d = 1'b0;
                  state_d = S_RELEASE;
               end else if ((TIMEOUT > 0) && (tmo_q == TMO_LAST)) begin
                  start_d = 1'b0;
                  fault_d = 1'b1;
                  state_d = S_FAULT;
               end else begin
                  tmo_d = tmo_q + 1'b1;
               end
            end
            S_RELEASE: begin
               if (!cpu_done) begin
                  if (region_end && !loop_mode) begin
                     halted_d = 1'b1;
                     state_d  = S_HALTED;
                  end else begin
                     pc_d    = region_end ? base : pc_q + 1'b1;
                     state_d = step_mode ? S_PAUSE : S_FETCH;
                  end
               end
            end
            S_PAUSE: begin
               if (go) begin
                  state_d = S_FETCH;
               end
            end
            S_FAULT: begin
               start_d = 1'b0;
               fault_d = 1'b1;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         pc_q     <= '0;
         prog_q   <= '0;
         instr_q  <= '0;
         data_q   <= '0;
         start_q  <= 1'b0;
         halted_q <= 1'b0;
         fault_q  <= 1'b0;
         tmo_q    <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         prog_q   <= prog_d;
         instr_q  <= instr_d;
         data_q   <= data_d;
         start_q  <= start_d;
         halted_q <= halted_d;
         fault_q  <= fault_d;
         tmo_q    <= tmo_d;
      end
   end

   assign cpu_start   = start_q;
   assign instruction = instr_q;
   assign data_var    = data_q;
   assign pc          = pc_q;
   assign halted      = halted_q;
   assign fault       = fault_q;
   assign busy        = (state_q == S_ISSUE)   || (state_q == S_WAIT) ||
                        (state_q == S_RELEASE) || (state_q == S_PAUSE);

endmodule

// File: tb/tb_cpu_program_sequencer.sv
// Directed bench for cpu_program_sequencer: vector table for a plain run,
// hand-written sequences for loop, step, timeout, reset and rewrite cases.
module tb_cpu_program_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       go, abort, loop_mode, step_mode;
   logic [1:0] prog_sel;
   logic       wr_en;
   logic [5:0] wr_addr;
   logic [8:0] wr_instr;
   logic [15:0] wr_data;
   logic       cpu_done;
   logic       cpu_start;
   logic [8:0] instruction;
   logic [15:0] data_var;
   logic [5:0] pc;
   logic       busy, halted, fault;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [5:0]  pc;
      logic [8:0]  instr;
      logic [15:0] data;
   } iss_t;

   typedef struct {
      logic [5:0]  addr;
      logic [8:0]  instr;
      logic [15:0] data;
      bit          exp_issue;
   } vec_t;

   iss_t log_q[$];
   vec_t t1[4];
   bit   cpu_en = 1'b1;
   bit   prev_start = 1'b0;
   int   done_cnt = 0;

   cpu_program_sequencer #(.TIMEOUT(8)) dut (
      .clk(clk), .rst(rst), .go(go), .abort(abort),
      .prog_sel(prog_sel), .loop_mode(loop_mode),
      .step_mode(step_mode), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_instr(wr_instr), .wr_data(wr_data), .cpu_done(cpu_done),
      .cpu_start(cpu_start), .instruction(instruction),
      .data_var(data_var), .pc(pc), .busy(busy),
      .halted(halted), .fault(fault)
   );

   always #5 clk = ~clk;

   // cpu model: done 3 cycles after start seen, dropped once start falls
   always @(negedge clk) begin
      if (!cpu_en || !cpu_start) begin
         done_cnt = 0;
         cpu_done = 1'b0;
      end else begin
         done_cnt++;
         if (done_cnt >= 3) cpu_done = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (cpu_start && !prev_start)
         log_q.push_back('{pc, instruction, data_var});
      prev_start = cpu_start;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [5:0] a, input logic [8:0] i,
                     input logic [15:0] d);
      wr_en = 1'b1; wr_addr = a; wr_instr = i; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic pulse_go(input logic [1:0] p);
      prog_sel = p; go = 1'b1;
      @(negedge clk);
      go = 1'b0;
   endtask

   task automatic wait_halt(input string name);
      int n = 0;
      while (!halted && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk(name, halted, 1);
   endtask

   task automatic wait_log(input int sz, input string name);
      int n = 0;
      while (log_q.size() < sz && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk(name, log_q.size(), sz);
   endtask

   task automatic check_t1(input string tag);
      int j = 0;
      chk({tag, "_count"}, log_q.size(), 3);
      for (int k = 0; k < 4; k++) begin
         if (t1[k].exp_issue && j < log_q.size()) begin
            chk({tag, "_pc"},    log_q[j].pc,    t1[k].addr);
            chk({tag, "_instr"}, log_q[j].instr, t1[k].instr);
            chk({tag, "_data"},  log_q[j].data,  t1[k].data);
            j++;
         end
      end
   endtask

   initial begin
      int cnt;
      t1[0] = '{6'd16, 9'h011, 16'hA001, 1'b1};
      t1[1] = '{6'd17, 9'h022, 16'hB002, 1'b1};
      t1[2] = '{6'd18, 9'h033, 16'hC003, 1'b1};
      t1[3] = '{6'd19, 9'h1FF, 16'hDEAD, 1'b0};

      rst = 1'b1; go = 0; abort = 0; prog_sel = 0;
      loop_mode = 0; step_mode = 0; wr_en = 0;
      wr_addr = 0; wr_instr = 0; wr_data = 0; cpu_done = 0;
      repeat (3) @(negedge clk);
      chk("rst_start",  cpu_start,   0);
      chk("rst_instr",  instruction, 0);
      chk("rst_data",   data_var,    0);
      chk("rst_pc",     pc,          0);
      chk("rst_busy",   busy,        0);
      chk("rst_halted", halted,      0);
      chk("rst_fault",  fault,       0);
      rst = 1'b0;
      @(negedge clk);

      // plain run of region 1 from the vector table
      for (int k = 0; k < 4; k++) wr(t1[k].addr, t1[k].instr, t1[k].data);
      log_q.delete();
      pulse_go(2'd1);
      chk("fetch_busy",  busy,      0);
      chk("fetch_start", cpu_start, 0);
      @(negedge clk);
      chk("issue_start", cpu_start,   1);
      chk("issue_instr", instruction, 9'h011);
      chk("issue_pc",    pc,          16);
      wait_halt("t1_halt");
      chk("t1_busy", busy, 0);
      chk("t1_pc",   pc,   19);
      check_t1("t1");

      // loop mode on region 0
      for (int k = 0; k < 16; k++)
         wr(6'(k), 9'(k + 1), 16'h0100 + 16'(k));
      log_q.delete();
      loop_mode = 1'b1;
      pulse_go(2'd0);
      wait_log(17, "loop_wrap_wait");
      if (log_q.size() >= 17) chk("loop_wrap_pc", log_q[16].pc, 0);
      wait_log(32, "loop_round2");
      loop_mode = 1'b0;
      wait_halt("loop_halt");
      chk("loop_count", log_q.size(), 32);
      chk("loop_pc", pc, 15);
      for (int k = 0; k < log_q.size(); k++)
         chk("loop_entry", {log_q[k].pc, log_q[k].instr},
             {6'(k % 16), 9'((k % 16) + 1)});

      // single step on region 2
      wr(6'd32, 9'h055, 16'hD005);
      wr(6'd33, 9'h066, 16'hD006);
      wr(6'd34, 9'h1FF, 16'h0000);
      log_q.delete();
      step_mode = 1'b1;
      pulse_go(2'd2);
      chk("step_halt_clr", halted, 0);
      repeat (12) @(negedge clk);
      chk("pause1_busy",  busy,         1);
      chk("pause1_start", cpu_start,    0);
      chk("pause1_pc",    pc,           33);
      chk("pause1_count", log_q.size(), 1);
      repeat (10) @(negedge clk);
      chk("pause1_hold", log_q.size(), 1);
      pulse_go(2'd0);
      repeat (12) @(negedge clk);
      chk("pause2_busy",  busy,         1);
      chk("pause2_pc",    pc,           34);
      chk("pause2_count", log_q.size(), 2);
      if (log_q.size() >= 2) chk("pause2_instr", log_q[1].instr, 9'h066);
      pulse_go(2'd0);
      repeat (4) @(negedge clk);
      chk("step_halted", halted, 1);
      chk("step_busy",   busy,   0);
      chk("step_count",  log_q.size(), 2);
      step_mode = 1'b0;

      // done timeout on region 3
      wr(6'd48, 9'h077, 16'h7007);
      cpu_en = 1'b0;
      pulse_go(2'd3);
      cnt = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (fault) break;
         if (cpu_start) cnt++;
      end
      chk("tmo_start_cycles", cnt, 9);
      chk("tmo_fault", fault,     1);
      chk("tmo_start", cpu_start, 0);
      pulse_go(2'd3);
      repeat (3) @(negedge clk);
      chk("tmo_go_ign_fault", fault,     1);
      chk("tmo_go_ign_start", cpu_start, 0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_fault", fault,       0);
      chk("abort_busy",  busy,        0);
      chk("abort_pc",    pc,          48);
      chk("abort_instr", instruction, 9'h077);

      // abort and go together stay in IDLE
      log_q.delete();
      abort = 1'b1;
      pulse_go(2'd1);
      abort = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_beats_go", {busy, cpu_start, 6'(log_q.size())}, 0);

      // asynchronous reset during WAIT
      pulse_go(2'd1);
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_start", cpu_start, 1);
      #3 rst = 1'b1;
      #1;
      chk("arst_outputs",
          {cpu_start, instruction, data_var, pc, busy, halted, fault}, 0);
      @(negedge clk);
      rst = 1'b0;
      cpu_en = 1'b1;
      @(negedge clk);
      log_q.delete();
      pulse_go(2'd1);
      wait_halt("rst_rerun_halt");
      check_t1("rerun");

      // rewrite the issued entry while waiting
      log_q.delete();
      loop_mode = 1'b1;
      pulse_go(2'd0);
      wait_log(1, "rw_first_issue");
      wr(6'd0, 9'h0AA, 16'hBEEF);
      chk("rw_instr_hold", instruction, 9'h001);
      chk("rw_data_hold",  data_var,    16'h0100);
      wait_log(17, "rw_refetch");
      if (log_q.size() >= 17) begin
         chk("rw_new_pc",    log_q[16].pc,    0);
         chk("rw_new_instr", log_q[16].instr, 9'h0AA);
         chk("rw_new_data",  log_q[16].data,  16'hBEEF);
      end
      loop_mode = 1'b0;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      @(negedge clk);
      chk("rw_abort_busy", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
